// File: rtl/stencil_pkg.sv
// Shared widths, pixel-position type and raster-position helper for the stencil unit.
package stencil_pkg;

    localparam int MAX_DIM = 4096;

    function automatic int sum_w(input int data_w, input int k);
        return data_w + $clog2(k * k);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

    // Wide enough for any legal row/column index 0..MAX_DIM-1.
    localparam int POS_W = cnt_w(MAX_DIM);

    typedef struct packed {
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } pix_pos_t;

    // Raster advance: column wraps into the next row, last row wraps into the next frame.
    function automatic pix_pos_t pos_advance(input pix_pos_t p, input int img_w, input int img_h);
        pix_pos_t n;
        n = p;
        if (p.col == POS_W'(img_w - 1)) begin
            n.col = '0;
            if (p.row == POS_W'(img_h - 1)) begin
                n.row = '0;
            end else begin
                n.row = p.row + 1'b1;
            end
        end else begin
            n.col = p.col + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stencil_linebuf.sv
// K-1 cascaded line buffers: every row shares one address; reads are combinational and
// return the pre-write contents, so the write at the same address sees the old value.
module stencil_linebuf
    import stencil_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 64
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [cnt_w(IMG_W)-1:0]    i_addr,
    input  logic [DATA_W-1:0]          i_data,
    output logic [(K-1)*DATA_W-1:0]    o_rd_data
);

    genvar gi;

    // Row 0 holds the most recent previous image row, row K-2 the oldest.
    for (gi = 0; gi < K - 1; gi++) begin : g_row
        logic [DATA_W-1:0] r_mem [IMG_W];
        logic [DATA_W-1:0] w_wr_data;

        if (gi == 0) begin : g_head
            assign w_wr_data = i_data;
        end else begin : g_tail
            assign w_wr_data = o_rd_data[(gi-1)*DATA_W +: DATA_W];
        end

        always_ff @(posedge clk) begin
            if (i_wr_en) begin
                r_mem[i_addr] <= w_wr_data;
            end
        end

        assign o_rd_data[gi*DATA_W +: DATA_W] = r_mem[i_addr];
    end

endmodule

// File: rtl/stencil_sum_ub.sv
// Streaming KxK window-sum unit with valid/ready on both sides and one output register.
// Define STENCIL_LAST_EN to add the out_last end-of-frame marker.
module stencil_sum_ub
    import stencil_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [sum_w(DATA_W, K)-1:0]   out_sum
`ifdef STENCIL_LAST_EN
    ,
    output logic                          out_last
`endif
);

    localparam int SUM_W = sum_w(DATA_W, K);
    localparam int COL_W = cnt_w(IMG_W);
    localparam int NTERM = K * K;
    localparam int NLEAF = 1 << $clog2(NTERM);
    localparam logic [POS_W-1:0] EDGE = POS_W'(K - 1);

    pix_pos_t                r_pos;
    logic [DATA_W-1:0]       r_win [K][K];
    logic [DATA_W-1:0]       w_newcol [K];
    logic [(K-1)*DATA_W-1:0] w_lb_rd;
    logic [SUM_W-1:0]        w_node [2*NLEAF-1];
    logic                    w_accept;
    logic                    w_emit;
    logic                    r_out_valid;
    logic [SUM_W-1:0]        r_out_sum;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = (r_pos.row >= EDGE) && (r_pos.col >= EDGE);

    stencil_linebuf #(
        .DATA_W (DATA_W),
        .K      (K),
        .IMG_W  (IMG_W)
    ) u_linebuf (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_addr    (r_pos.col[COL_W-1:0]),
        .i_data    (in_data),
        .o_rd_data (w_lb_rd)
    );

    genvar gi;

    // Incoming column, top (oldest row) to bottom (current pixel).
    for (gi = 0; gi < K - 1; gi++) begin : g_newcol
        assign w_newcol[gi] = w_lb_rd[(K-2-gi)*DATA_W +: DATA_W];
    end
    assign w_newcol[K-1] = in_data;

    // Tree leaves form the post-shift window so the sum is ready at the accepting edge.
    for (gi = 0; gi < NLEAF; gi++) begin : g_leaf
        if (gi < NTERM) begin : g_term
            localparam int ROW = gi / K;
            localparam int COL = gi % K;
            if (COL == K - 1) begin : g_new
                assign w_node[NLEAF-1+gi] = SUM_W'(w_newcol[ROW]);
            end else begin : g_old
                assign w_node[NLEAF-1+gi] = SUM_W'(r_win[ROW][COL+1]);
            end
        end else begin : g_pad
            assign w_node[NLEAF-1+gi] = '0;
        end
    end

    for (gi = 0; gi < NLEAF - 1; gi++) begin : g_node
        assign w_node[gi] = w_node[2*gi+1] + w_node[2*gi+2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (w_accept) begin
            r_pos <= pos_advance(r_pos, IMG_W, IMG_H);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_newcol[r];
            end
        end
    end

    // A new accept always frees the register, so load and consume can share one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else if (w_accept) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_sum <= w_node[0];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

`ifdef STENCIL_LAST_EN
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(IMG_W - 1);

    logic r_out_last;
    logic w_is_last;

    assign w_is_last = w_emit && (r_pos.row == LAST_ROW) && (r_pos.col == LAST_COL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_last <= 1'b0;
        end else if (w_accept) begin
            r_out_last <= w_is_last;
        end else if (out_ready) begin
            r_out_last <= 1'b0;
        end
    end

    assign out_last = r_out_last;
`endif

endmodule
